// File: rtl/hub75_pkg.sv
// hub75_pkg: shared state encoding, RGB bit positions and chain sizing helpers for the HUB75 blocks
package hub75_pkg;
    typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_SHIFT} state_t;
    localparam int RGB_R0 = 5;
    localparam int RGB_G0 = 4;
    localparam int RGB_B0 = 3;
    localparam int RGB_R1 = 2;
    localparam int RGB_G1 = 1;
    localparam int RGB_B1 = 0;
    function automatic int led_n(input int width, input int chain);
        return width * chain;
    endfunction
    function automatic int led_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/hub75_sync_edge.sv
// hub75_sync_edge: 2-flop synchronizer plus previous-value register with rise/fall detect
module hub75_sync_edge #(
    parameter int W = 1,
    parameter logic [W-1:0] RST = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] s_o,
    output logic [W-1:0] p_o,
    output logic [W-1:0] rise_o,
    output logic [W-1:0] fall_o
);
    logic [W-1:0] m_q, s_q, p_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            m_q <= RST;
            s_q <= RST;
            p_q <= RST;
        end else begin
            m_q <= d_i;
            s_q <= m_q;
            p_q <= s_q;
        end
    end
    assign s_o    = s_q;
    assign p_o    = p_q;
    assign rise_o = s_q & ~p_q;
    assign fall_o = ~s_q & p_q;
endmodule

// File: rtl/hub75_capture.sv
// hub75_capture: oversampling HUB75 chain receiver; pixels, latches, on-times, frame marks.
// Define HUB75_CAP_CHECK_EN to build in the sticky protocol checker driving proto_err.
module hub75_capture
    import hub75_pkg::*;
#(
    parameter int C_LED_CHAIN_LENGTH = 4,
    parameter int C_LED_NBANKS       = 16,
    parameter int C_LED_WIDTH        = 32,
    parameter int C_OE_CNT_W         = 24,
    localparam int N  = led_n(C_LED_WIDTH, C_LED_CHAIN_LENGTH),
    localparam int XW = led_w(N),
    localparam int BW = led_w(C_LED_NBANKS)
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  led_clk,
    input  logic                  led_stb,
    input  logic                  led_oe,
    input  logic [BW-1:0]         led_bank,
    input  logic [5:0]            led_rgb,
    output logic                  pix_valid,
    output logic [XW-1:0]         pix_x,
    output logic [5:0]            pix_rgb,
    output logic                  row_valid,
    output logic [BW-1:0]         row_bank,
    output logic [XW:0]           row_len,
    output logic                  oe_valid,
    output logic [C_OE_CNT_W-1:0] oe_cycles,
    output logic [BW-1:0]         oe_bank,
    output logic                  frame_start,
    output logic                  proto_err
);
    localparam logic [XW:0]   NV   = (XW+1)'(N);
    localparam logic [BW-1:0] LAST = BW'(C_LED_NBANKS - 1);
    logic [2:0] ctl_s, ctl_p_unused, ctl_rise, ctl_fall;
    logic [BW+5:0] dat_s, dat_p_unused, dat_rise_unused, dat_fall_unused;
    logic unused_clk_fall;
    state_t state_q, state_d;
    logic [XW:0] cnt_q, cnt_d, cnt_inc;
    logic [C_OE_CNT_W-1:0] oe_cnt_q, oe_cnt_d;
    logic [1:0] live_q;
    logic arm_q, active, clk_rise, stb_rise, oe_rise, pix_emit, latch, frame, oe_emit;
    logic [BW-1:0] s_bank;
    logic [5:0] s_rgb;
    hub75_sync_edge #(.W(3), .RST(3'b001)) u_ctl (
        .clk(sys_clk), .rst(sys_rst), .d_i({led_clk, led_stb, led_oe}),
        .s_o(ctl_s), .p_o(ctl_p_unused), .rise_o(ctl_rise), .fall_o(ctl_fall)
    );
    hub75_sync_edge #(.W(BW+6)) u_dat (
        .clk(sys_clk), .rst(sys_rst), .d_i({led_bank, led_rgb}),
        .s_o(dat_s), .p_o(dat_p_unused), .rise_o(dat_rise_unused), .fall_o(dat_fall_unused)
    );
    assign unused_clk_fall = ctl_fall[2];
    assign {s_bank, s_rgb} = dat_s;
    assign {clk_rise, stb_rise, oe_rise} = ctl_rise;
    always_comb begin
        active   = state_q != ST_SYNC;
        cnt_inc  = (active && clk_rise && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
        pix_emit = active && clk_rise && cnt_q < NV;
        latch    = active && stb_rise;
        frame    = latch && row_bank == LAST && s_bank == '0;
        cnt_d    = latch ? '0 : cnt_inc;
        state_d  = latch ? ST_IDLE :
                   (active && clk_rise) ? ST_SHIFT :
                   (!active && ctl_fall[1]) ? ST_IDLE : state_q;
        oe_cnt_d = ctl_fall[0] ? C_OE_CNT_W'(1) :
                   (!ctl_s[0] && !(&oe_cnt_q)) ? oe_cnt_q + 1'b1 : oe_cnt_q;
        oe_emit  = oe_rise && arm_q;
    end
    // a window already open when reset releases is dropped: arm only once OE is seen high post-reset
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= ST_SYNC;
            cnt_q       <= '0;
            oe_cnt_q    <= '0;
            live_q      <= '0;
            arm_q       <= 1'b0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_rgb     <= '0;
            row_valid   <= 1'b0;
            row_bank    <= '0;
            row_len     <= '0;
            oe_valid    <= 1'b0;
            oe_cycles   <= '0;
            oe_bank     <= '0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            oe_cnt_q    <= oe_cnt_d;
            live_q      <= {live_q[0], 1'b1};
            arm_q       <= arm_q | (live_q[1] & ctl_s[0]);
            pix_valid   <= pix_emit;
            row_valid   <= latch;
            oe_valid    <= oe_emit;
            frame_start <= frame;
            if (pix_emit) begin
                pix_x   <= cnt_q[XW-1:0];
                pix_rgb <= s_rgb;
            end
            if (latch) begin
                row_bank <= s_bank;
                row_len  <= cnt_inc;
            end
            if (oe_emit) begin
                oe_cycles <= oe_cnt_q;
                oe_bank   <= s_bank;
            end
        end
    end
`ifdef HUB75_CAP_CHECK_EN
    logic err_q;
    always_ff @(posedge sys_clk) begin
        err_q <= sys_rst ? 1'b0 : err_q | (clk_rise & ~ctl_s[0]) | (stb_rise & ctl_s[2])
                 | (clk_rise & ctl_s[1]) | (latch & cnt_inc != NV);
    end
    assign proto_err = err_q;
`else
    logic unused_lvl;
    assign unused_lvl = &{1'b0, ctl_s[2:1]};
    assign proto_err  = 1'b0;
`endif
endmodule

// File: tb/tb_hub75_capture.sv
// tb_hub75_capture: randomized directed scenarios checked against an event-level model of the receiver
module tb_hub75_capture;
    localparam int NB = 16, N = 128, OEW = 10, OEMAX = 1023;
    typedef struct {int k; int a; int b; int c;} ev_t;
    logic sys_clk = 0, sys_rst = 1, led_clk = 0, led_stb = 0, led_oe = 1;
    logic [3:0] led_bank = 0;
    logic [5:0] led_rgb = 0;
    logic pix_valid, row_valid, oe_valid, frame_start, proto_err;
    logic [6:0] pix_x;
    logic [5:0] pix_rgb;
    logic [3:0] row_bank, oe_bank;
    logic [7:0] row_len;
    logic [OEW-1:0] oe_cycles;
    int checks = 0, errors = 0;
    bit synced, exp_err;
    int cnt, prev_bank;
    ev_t exp_q[$], got_q[$];

    hub75_capture #(.C_OE_CNT_W(OEW)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .led_clk(led_clk), .led_stb(led_stb),
        .led_oe(led_oe), .led_bank(led_bank), .led_rgb(led_rgb),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_rgb(pix_rgb),
        .row_valid(row_valid), .row_bank(row_bank), .row_len(row_len),
        .oe_valid(oe_valid), .oe_cycles(oe_cycles), .oe_bank(oe_bank),
        .frame_start(frame_start), .proto_err(proto_err)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (pix_valid) got_q.push_back('{0, int'(pix_x), int'(pix_rgb), 0});
            if (row_valid) got_q.push_back('{1, int'(row_bank), int'(row_len), int'(frame_start)});
            if (oe_valid) got_q.push_back('{2, int'(oe_cycles), int'(oe_bank), 0});
            if (frame_start && !row_valid) got_q.push_back('{3, 0, 0, 1});
        end
    end

    task automatic chk(input string tag, input int got, input int expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, expv);
        end
    endtask

    function automatic int err_exp();
`ifdef HUB75_CAP_CHECK_EN
        return int'(exp_err);
`else
        return 0;
`endif
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic model_pix(input logic [5:0] rgb);
        if (!led_oe || led_stb) exp_err = 1;
        if (synced) begin
            if (cnt < N) exp_q.push_back('{0, cnt, int'(rgb), 0});
            cnt = (cnt < 255) ? cnt + 1 : 255;
        end
    endtask

    task automatic model_latch(input int bank);
        if (led_clk) exp_err = 1;
        if (synced) begin
            exp_q.push_back('{1, bank, cnt, int'(prev_bank == NB - 1 && bank == 0)});
            if (cnt != N) exp_err = 1;
            prev_bank = bank;
            cnt = 0;
        end
    endtask

    task automatic px(input logic [5:0] rgb);
        led_rgb = rgb;
        led_clk = 1;
        model_pix(rgb);
        cyc(2);
        led_clk = 0;
        cyc(2);
    endtask

    task automatic lt(input int bank);
        led_bank = 4'(bank);
        led_stb = 1;
        model_latch(bank);
        cyc(2);
        led_stb = 0;
        synced = 1;
        cyc(2);
    endtask

    task automatic px_lt(input logic [5:0] rgb, input int bank);
        led_rgb = rgb;
        led_bank = 4'(bank);
        led_clk = 1;
        led_stb = 1;
        model_pix(rgb);
        model_latch(bank);
        cyc(2);
        led_clk = 0;
        led_stb = 0;
        synced = 1;
        cyc(2);
    endtask

    task automatic ow(input int len, input int bank);
        led_bank = 4'(bank);
        led_oe = 0;
        cyc(len);
        led_oe = 1;
        exp_q.push_back('{2, (len < OEMAX) ? len : OEMAX, bank, 0});
        cyc(4);
    endtask

    task automatic do_reset();
        sys_rst = 1;
        cyc(3);
        sys_rst = 0;
        synced = 0;
        exp_err = 0;
        cnt = 0;
        prev_bank = 0;
        got_q.delete();
        exp_q.delete();
        cyc(4);
    endtask

    task automatic flush_cmp(input string tag);
        cyc(6);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_%0d_kind", tag, i), got_q[i].k, exp_q[i].k);
            chk($sformatf("%s_%0d_a", tag, i), got_q[i].a, exp_q[i].a);
            chk($sformatf("%s_%0d_b", tag, i), got_q[i].b, exp_q[i].b);
            chk($sformatf("%s_%0d_c", tag, i), got_q[i].c, exp_q[i].c);
        end
        got_q.delete();
        exp_q.delete();
        chk({tag, "_proto_err"}, int'(proto_err), err_exp());
    endtask

    initial begin
        logic [5:0] r;
        cyc(3);
        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_pix_x", int'(pix_x), 0);
        chk("rst_pix_rgb", int'(pix_rgb), 0);
        chk("rst_row_valid", int'(row_valid), 0);
        chk("rst_row_bank", int'(row_bank), 0);
        chk("rst_row_len", int'(row_len), 0);
        chk("rst_oe_valid", int'(oe_valid), 0);
        chk("rst_oe_cycles", int'(oe_cycles), 0);
        chk("rst_oe_bank", int'(oe_bank), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_proto_err", int'(proto_err), 0);
        do_reset();
        // clean row, with the first pixel's 3-cycle latency checked explicitly
        lt(0);
        r = 6'($urandom);
        led_rgb = r;
        led_clk = 1;
        model_pix(r);
        cyc(1);
        chk("lat_c1", int'(pix_valid), 0);
        cyc(1);
        chk("lat_c2", int'(pix_valid), 0);
        led_clk = 0;
        cyc(1);
        chk("lat_c3", int'(pix_valid), 1);
        chk("lat_x", int'(pix_x), 0);
        chk("lat_rgb", int'(pix_rgb), int'(r));
        cyc(1);
        chk("lat_c4", int'(pix_valid), 0);
        cyc(1);
        for (int i = 1; i < N; i++) px(6'($urandom));
        lt(3);
        flush_cmp("clean");
        // reset mid-OE window and mid-row: nothing reported until the first strobe fall
        led_oe = 0;
        cyc(10);
        do_reset();
        cyc(20);
        led_oe = 1;
        cyc(4);
        for (int i = 0; i < 40; i++) px(6'($urandom));
        lt(7);
        flush_cmp("startup");
        for (int i = 0; i < 5; i++) px(6'($urandom));
        lt(2);
        flush_cmp("post_sync");
        // on-time windows including saturation
        ow(1000, 5);
        ow(1100, $urandom_range(0, NB - 1));
        for (int i = 0; i < 4; i++) ow($urandom_range(2, 60), $urandom_range(0, NB - 1));
        flush_cmp("ontime");
        lt(14);
        lt(15);
        lt(0);
        lt(0);
        flush_cmp("frame");
        // short row ending with a clock rise coincident with the strobe rise
        do_reset();
        lt(0);
        for (int i = 0; i < N - 2; i++) px(6'($urandom));
        px_lt(6'($urandom), 1);
        flush_cmp("short");
        // runaway row, then a clock rise during an on-time window
        do_reset();
        lt(0);
        for (int i = 0; i < 300; i++) px(6'($urandom));
        lt(9);
        flush_cmp("runaway");
        led_oe = 0;
        cyc(3);
        px(6'($urandom));
        cyc(2);
        led_oe = 1;
        exp_q.push_back('{2, 9, 9, 0});
        flush_cmp("ghost");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
